// File: rtl/l1a_blk_reader.sv
// Read-side controller for the L1A/SCA-block FIFO: pops one trigger entry, sends its header,
// walks the SCA sample addresses of its block(s), then hands the block(s) back to the free pool.
//
// state  | meaning
// IDLE   | waiting for the FIFO to go non-empty
// WAIT   | one cycle for the registered FIFO head to settle
// CAPT   | POP strobe, head fields latched
// HDR    | header offered until accepted
// SAMP   | sample addresses offered, one per accepted beat
// RLS    | release strobe for first block, then second block if used
// DONE   | event counter bump
module l1a_blk_reader #(
  parameter int NSAMP = 8,
  parameter int TMR   = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EMPTY,
  input  logic [3:0]  BLKIN,
  input  logic [7:0]  L1PIN,
  input  logic        LCT_PH_IN,
  input  logic        SCND_BLK_IN,
  input  logic        SCND_SH_IN,
  input  logic        DGSCAFULL,
  output logic        POP,
  output logic        HDR_VLD,
  input  logic        HDR_RDY,
  output logic [11:0] HDR,
  output logic        SAMP_VLD,
  input  logic        SAMP_RDY,
  output logic [3:0]  SAMP_BLK,
  output logic [3:0]  SAMP_IDX,
  output logic        SAMP_LAST,
  output logic        RLS,
  output logic [3:0]  RLS_BLK,
  output logic        BUSY,
  output logic [7:0]  NEVT
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_CAPT, S_HDR, S_SAMP, S_RLS, S_DONE
  } st_e;

  localparam logic [3:0] IDX_LAST = 4'(NSAMP - 1);

  st_e        state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] blk_q, blk_d;
  logic [7:0] l1p_q, l1p_d;
  logic       lct_q, lct_d, scnd_q, scnd_d, sh_q, sh_d, ovf_q, ovf_d;
  logic       second_q, second_d;
  logic [3:0] samp_blk_q, samp_blk_d;
  logic [3:0] rls_blk_q, rls_blk_d;
  logic [7:0] nevt_q, nevt_d;
  logic       pop_q, hdr_vld_q, samp_vld_q, samp_last_q, samp_last_d, rls_q, busy_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    blk_d       = blk_q;
    l1p_d       = l1p_q;
    lct_d       = lct_q;
    scnd_d      = scnd_q;
    sh_d        = sh_q;
    ovf_d       = ovf_q;
    second_d    = second_q;
    samp_blk_d  = samp_blk_q;
    rls_blk_d   = rls_blk_q;
    nevt_d      = nevt_q;
    case (state_q)
      S_IDLE: if (!EMPTY) state_d = S_WAIT;
      S_WAIT: state_d = S_CAPT;
      S_CAPT: begin
        blk_d   = BLKIN;
        l1p_d   = L1PIN;
        lct_d   = LCT_PH_IN;
        scnd_d  = SCND_BLK_IN;
        sh_d    = SCND_SH_IN;
        ovf_d   = DGSCAFULL;
        state_d = S_HDR;
      end
      S_HDR: if (hdr_vld_q && HDR_RDY) begin
        if (ovf_q) begin
          state_d = S_DONE;
        end else begin
          state_d    = S_SAMP;
          samp_blk_d = blk_q;
          idx_d      = '0;
          second_d   = 1'b0;
        end
      end
      S_SAMP: if (samp_vld_q && SAMP_RDY) begin
        if (idx_q != IDX_LAST) begin
          idx_d = idx_q + 4'd1;
        end else if (scnd_q && !second_q) begin
          samp_blk_d = blk_q + 4'd1;
          idx_d      = '0;
          second_d   = 1'b1;
        end else begin
          state_d   = S_RLS;
          rls_blk_d = blk_q;
          second_d  = 1'b0;
        end
      end
      // second_q is reused here to mark that the second block's release is in flight
      S_RLS: if (scnd_q && !second_q) begin
        second_d  = 1'b1;
        rls_blk_d = blk_q + 4'd1;
      end else begin
        state_d = S_DONE;
      end
      S_DONE: begin
        nevt_d  = nevt_q + 8'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    samp_last_d = (state_d == S_SAMP) && (idx_d == IDX_LAST) && (!scnd_q || second_d);
  end

  generate
    if (TMR != 0) begin : g_tmr
      st_e        st_t  [3];
      logic [3:0] idx_t [3];
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          for (int i = 0; i < 3; i++) begin
            st_t[i]  <= S_IDLE;
            idx_t[i] <= '0;
          end
        end else begin
          for (int i = 0; i < 3; i++) begin
            st_t[i]  <= state_d;
            idx_t[i] <= idx_d;
          end
        end
      end
      assign state_q = st_e'((st_t[0] & st_t[1]) | (st_t[0] & st_t[2]) | (st_t[1] & st_t[2]));
      assign idx_q   = (idx_t[0] & idx_t[1]) | (idx_t[0] & idx_t[2]) | (idx_t[1] & idx_t[2]);
    end else begin : g_single
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          state_q <= S_IDLE;
          idx_q   <= '0;
        end else begin
          state_q <= state_d;
          idx_q   <= idx_d;
        end
      end
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      blk_q       <= '0;
      l1p_q       <= '0;
      lct_q       <= 1'b0;
      scnd_q      <= 1'b0;
      sh_q        <= 1'b0;
      ovf_q       <= 1'b0;
      second_q    <= 1'b0;
      samp_blk_q  <= '0;
      rls_blk_q   <= '0;
      nevt_q      <= '0;
      pop_q       <= 1'b0;
      hdr_vld_q   <= 1'b0;
      samp_vld_q  <= 1'b0;
      samp_last_q <= 1'b0;
      rls_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      blk_q       <= blk_d;
      l1p_q       <= l1p_d;
      lct_q       <= lct_d;
      scnd_q      <= scnd_d;
      sh_q        <= sh_d;
      ovf_q       <= ovf_d;
      second_q    <= second_d;
      samp_blk_q  <= samp_blk_d;
      rls_blk_q   <= rls_blk_d;
      nevt_q      <= nevt_d;
      pop_q       <= (state_d == S_CAPT);
      hdr_vld_q   <= (state_d == S_HDR);
      samp_vld_q  <= (state_d == S_SAMP);
      samp_last_q <= samp_last_d;
      rls_q       <= (state_d == S_RLS);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign POP       = pop_q;
  assign HDR_VLD   = hdr_vld_q;
  assign HDR       = {ovf_q, sh_q, lct_q, scnd_q, l1p_q};
  assign SAMP_VLD  = samp_vld_q;
  assign SAMP_BLK  = samp_blk_q;
  assign SAMP_IDX  = idx_q;
  assign SAMP_LAST = samp_last_q;
  assign RLS       = rls_q;
  assign RLS_BLK   = rls_blk_q;
  assign BUSY      = busy_q;
  assign NEVT      = nevt_q;

endmodule

// File: tb/tb_l1a_blk_reader.sv
// Directed bench for l1a_blk_reader: FIFO model feeding the head, monitor logging handshakes,
// one task per scenario with hand-computed expectations.
module tb_l1a_blk_reader;
  localparam int NSAMP = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EMPTY;
  logic [3:0]  BLKIN;
  logic [7:0]  L1PIN;
  logic        LCT_PH_IN, SCND_BLK_IN, SCND_SH_IN, DGSCAFULL;
  logic        POP, HDR_VLD, SAMP_VLD, SAMP_LAST, RLS, BUSY;
  logic        HDR_RDY = 1'b1;
  logic        SAMP_RDY = 1'b1;
  logic [11:0] HDR;
  logic [3:0]  SAMP_BLK, SAMP_IDX, RLS_BLK;
  logic [7:0]  NEVT;

  l1a_blk_reader #(.NSAMP(NSAMP), .TMR(0)) dut (
    .CLK(CLK), .RST(RST), .EMPTY(EMPTY), .BLKIN(BLKIN), .L1PIN(L1PIN),
    .LCT_PH_IN(LCT_PH_IN), .SCND_BLK_IN(SCND_BLK_IN), .SCND_SH_IN(SCND_SH_IN),
    .DGSCAFULL(DGSCAFULL), .POP(POP), .HDR_VLD(HDR_VLD), .HDR_RDY(HDR_RDY), .HDR(HDR),
    .SAMP_VLD(SAMP_VLD), .SAMP_RDY(SAMP_RDY), .SAMP_BLK(SAMP_BLK), .SAMP_IDX(SAMP_IDX),
    .SAMP_LAST(SAMP_LAST), .RLS(RLS), .RLS_BLK(RLS_BLK), .BUSY(BUSY), .NEVT(NEVT)
  );

  always #5 CLK = ~CLK;

  // FIFO model: head advances on the edge that ends the POP cycle
  logic [3:0] f_blk [64];
  logic [7:0] f_l1p [64];
  logic       f_lct [64], f_scnd [64], f_sh [64], f_full [64];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       pop_s = 1'b0;

  assign EMPTY       = (wr_ptr == rd_ptr);
  assign BLKIN       = f_blk[rd_ptr % 64];
  assign L1PIN       = f_l1p[rd_ptr % 64];
  assign LCT_PH_IN   = f_lct[rd_ptr % 64];
  assign SCND_BLK_IN = f_scnd[rd_ptr % 64];
  assign SCND_SH_IN  = f_sh[rd_ptr % 64];
  assign DGSCAFULL   = f_full[rd_ptr % 64];

  always @(negedge CLK) pop_s <= POP;
  always @(posedge CLK) if (pop_s) rd_ptr <= rd_ptr + 1;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int          pop_cyc [$];
  logic [8:0]  beats [$];
  logic [3:0]  rls_blks [$];
  logic [11:0] hdrs [$];
  int          bad_pop = 0, stall_err = 0, hdr_err = 0, stall_cnt = 0, vld_cnt = 0;
  logic        p_stall = 1'b0, p_hstall = 1'b0, p_last = 1'b0;
  logic [3:0]  p_blk = '0, p_idx = '0;
  logic [11:0] p_hdr = '0;

  always @(negedge CLK) begin
    if (POP) begin
      pop_cyc.push_back(cyc);
      if (EMPTY) bad_pop <= bad_pop + 1;
    end
    if (SAMP_VLD) vld_cnt <= vld_cnt + 1;
    if (SAMP_VLD && SAMP_RDY) beats.push_back({SAMP_LAST, SAMP_BLK, SAMP_IDX});
    if (RLS) rls_blks.push_back(RLS_BLK);
    if (HDR_VLD && HDR_RDY) hdrs.push_back(HDR);
    if (!RST && p_stall && {SAMP_VLD, SAMP_BLK, SAMP_IDX, SAMP_LAST} !== {1'b1, p_blk, p_idx, p_last})
      stall_err <= stall_err + 1;
    if (!RST && p_hstall && {HDR_VLD, HDR} !== {1'b1, p_hdr}) hdr_err <= hdr_err + 1;
    if (SAMP_VLD && !SAMP_RDY) stall_cnt <= stall_cnt + 1;
    p_stall  <= SAMP_VLD && !SAMP_RDY;
    p_hstall <= HDR_VLD && !HDR_RDY;
    p_blk    <= SAMP_BLK;
    p_idx    <= SAMP_IDX;
    p_last   <= SAMP_LAST;
    p_hdr    <= HDR;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic push(input logic [3:0] b, input logic [7:0] l, input logic lct,
                      input logic scnd, input logic sh, input logic full);
    f_blk[wr_ptr % 64]  = b;
    f_l1p[wr_ptr % 64]  = l;
    f_lct[wr_ptr % 64]  = lct;
    f_scnd[wr_ptr % 64] = scnd;
    f_sh[wr_ptr % 64]   = sh;
    f_full[wr_ptr % 64] = full;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_idle(input logic [7:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (!BUSY && NEVT == target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    n_cmp++;
    if ({POP, HDR_VLD, SAMP_VLD, SAMP_LAST, RLS, BUSY, HDR, SAMP_BLK, SAMP_IDX, RLS_BLK, NEVT} !== 38'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got POP=%b HDR_VLD=%b SAMP_VLD=%b RLS=%b BUSY=%b HDR=%h NEVT=%0d, want all 0",
               POP, HDR_VLD, SAMP_VLD, RLS, BUSY, HDR, NEVT);
    end
    RST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      n_cmp++;
      if ({POP, HDR_VLD, SAMP_VLD, SAMP_LAST, RLS, BUSY, HDR, SAMP_BLK, SAMP_IDX, RLS_BLK, NEVT} !== 38'd0) begin
        n_err++;
        $display("FAIL idle_empty cycle %0d: got POP=%b BUSY=%b HDR_VLD=%b SAMP_VLD=%b RLS=%b, want all 0",
                 i, POP, BUSY, HDR_VLD, SAMP_VLD, RLS);
      end
    end
  endtask

  task automatic test_single();
    int b0, r0, h0, p0, t0;
    bit ok;
    logic [8:0] got, exp;
    b0 = beats.size(); r0 = rls_blks.size(); h0 = hdrs.size(); p0 = pop_cyc.size();
    @(posedge CLK); #1;
    t0 = cyc;
    push(4'd3, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle(8'd1, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL single_timeout: got idle=%b, want 1", ok); end
    n_cmp++;
    if (pop_cyc.size() - p0 !== 1) begin
      n_err++; $display("FAIL single_pop_count: got %0d, want 1", pop_cyc.size() - p0);
    end else begin
      n_cmp++;
      if (pop_cyc[p0] - t0 !== 2) begin
        n_err++; $display("FAIL single_pop_latency: got %0d, want 2", pop_cyc[p0] - t0);
      end
    end
    n_cmp++;
    if (hdrs.size() - h0 !== 1 || hdrs[h0] !== 12'h05A) begin
      n_err++; $display("FAIL single_hdr: got n=%0d hdr=%h, want n=1 hdr=05a", hdrs.size() - h0, hdrs[h0]);
    end
    n_cmp++;
    if (beats.size() - b0 !== NSAMP) begin
      n_err++; $display("FAIL single_beat_count: got %0d, want %0d", beats.size() - b0, NSAMP);
    end
    for (int i = 0; i < NSAMP; i++) begin
      got = (b0 + i < beats.size()) ? beats[b0 + i] : 9'h1FF;
      exp = {(i == NSAMP - 1), 4'd3, 4'(i)};
      n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL single_beat %0d: got %h, want %h", i, got, exp); end
    end
    n_cmp++;
    if (rls_blks.size() - r0 !== 1 || rls_blks[r0] !== 4'd3) begin
      n_err++; $display("FAIL single_rls: got n=%0d blk=%0d, want n=1 blk=3", rls_blks.size() - r0, rls_blks[r0]);
    end
    n_cmp++;
    if (NEVT !== 8'd1) begin n_err++; $display("FAIL single_nevt: got %0d, want 1", NEVT); end
  endtask

  task automatic test_second_block();
    int b0, r0, h0;
    bit ok;
    logic [8:0] got, exp;
    b0 = beats.size(); r0 = rls_blks.size(); h0 = hdrs.size();
    @(posedge CLK); #1;
    push(4'd15, 8'hC3, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_idle(8'd2, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL second_timeout: got idle=%b, want 1", ok); end
    n_cmp++;
    if (hdrs.size() - h0 !== 1 || hdrs[h0] !== 12'h3C3) begin
      n_err++; $display("FAIL second_hdr: got n=%0d hdr=%h, want n=1 hdr=3c3", hdrs.size() - h0, hdrs[h0]);
    end
    n_cmp++;
    if (beats.size() - b0 !== 2 * NSAMP) begin
      n_err++; $display("FAIL second_beat_count: got %0d, want %0d", beats.size() - b0, 2 * NSAMP);
    end
    for (int i = 0; i < 2 * NSAMP; i++) begin
      got = (b0 + i < beats.size()) ? beats[b0 + i] : 9'h1FF;
      exp = {(i == 2 * NSAMP - 1), (i < NSAMP) ? 4'd15 : 4'd0, 4'(i % NSAMP)};
      n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL second_beat %0d: got %h, want %h", i, got, exp); end
    end
    n_cmp++;
    if (rls_blks.size() - r0 !== 2 || rls_blks[r0] !== 4'd15 || rls_blks[r0 + 1] !== 4'd0) begin
      n_err++; $display("FAIL second_rls: got n=%0d first=%0d, want n=2 blks 15,0", rls_blks.size() - r0, rls_blks[r0]);
    end
  endtask

  task automatic test_ovf();
    int b0, r0, h0, v0, hw;
    bit ok;
    b0 = beats.size(); r0 = rls_blks.size(); h0 = hdrs.size(); v0 = vld_cnt;
    @(posedge CLK); #1;
    HDR_RDY = 1'b0;
    push(4'd7, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1);
    hw = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (HDR_VLD) begin hw = 1; break; end
    end
    n_cmp++;
    if (hw !== 1) begin n_err++; $display("FAIL ovf_hdr_vld_timeout: got %0d, want 1", hw); end
    repeat (3) @(posedge CLK);
    #1;
    n_cmp++;
    if ({HDR_VLD, HDR} !== {1'b1, 12'hC11}) begin
      n_err++; $display("FAIL ovf_hdr_held: got vld=%b hdr=%h, want vld=1 hdr=c11", HDR_VLD, HDR);
    end
    HDR_RDY = 1'b1;
    wait_idle(8'd3, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL ovf_timeout: got idle=%b, want 1", ok); end
    n_cmp++;
    if (hdrs.size() - h0 !== 1 || hdrs[h0] !== 12'hC11) begin
      n_err++; $display("FAIL ovf_hdr: got n=%0d hdr=%h, want n=1 hdr=c11", hdrs.size() - h0, hdrs[h0]);
    end
    n_cmp++;
    if (beats.size() - b0 !== 0 || vld_cnt - v0 !== 0) begin
      n_err++; $display("FAIL ovf_no_samples: got beats=%0d vld_cycles=%0d, want 0", beats.size() - b0, vld_cnt - v0);
    end
    n_cmp++;
    if (rls_blks.size() - r0 !== 0) begin
      n_err++; $display("FAIL ovf_no_rls: got %0d, want 0", rls_blks.size() - r0);
    end
    n_cmp++;
    if (hdr_err !== 0) begin n_err++; $display("FAIL ovf_hdr_stable: got %0d changes, want 0", hdr_err); end
  endtask

  task automatic test_stall();
    int b0, r0, s0, k;
    bit ok;
    logic [3:0] pat;
    logic [8:0] got, exp;
    b0 = beats.size(); r0 = rls_blks.size(); s0 = stall_cnt;
    pat = 4'b1001;
    ok = 1'b0;
    @(posedge CLK); #1;
    push(4'd5, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0);
    for (k = 0; k < 200; k++) begin
      @(posedge CLK); #1;
      SAMP_RDY = pat[k % 4];
      if (!BUSY && NEVT == 8'd4) begin ok = 1'b1; break; end
    end
    SAMP_RDY = 1'b1;
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL stall_timeout: got idle=%b, want 1", ok); end
    n_cmp++;
    if (beats.size() - b0 !== NSAMP) begin
      n_err++; $display("FAIL stall_beat_count: got %0d, want %0d", beats.size() - b0, NSAMP);
    end
    for (int i = 0; i < NSAMP; i++) begin
      got = (b0 + i < beats.size()) ? beats[b0 + i] : 9'h1FF;
      exp = {(i == NSAMP - 1), 4'd5, 4'(i)};
      n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL stall_beat %0d: got %h, want %h", i, got, exp); end
    end
    n_cmp++;
    if ((stall_cnt - s0 > 0) !== 1'b1) begin
      n_err++; $display("FAIL stall_exercised: got %0d stall cycles, want >0", stall_cnt - s0);
    end
    n_cmp++;
    if (stall_err !== 0) begin n_err++; $display("FAIL stall_hold: got %0d changes, want 0", stall_err); end
    n_cmp++;
    if (rls_blks.size() - r0 !== 1 || rls_blks[r0] !== 4'd5) begin
      n_err++; $display("FAIL stall_rls: got n=%0d blk=%0d, want n=1 blk=5", rls_blks.size() - r0, rls_blks[r0]);
    end
  endtask

  task automatic test_back_to_back();
    int p0, h0, t0;
    bit ok;
    p0 = pop_cyc.size(); h0 = hdrs.size();
    @(posedge CLK); #1;
    t0 = cyc;
    push(4'd1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    push(4'd2, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_idle(8'd6, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL b2b_timeout: got idle=%b, want 1", ok); end
    n_cmp++;
    if (pop_cyc.size() - p0 !== 2) begin
      n_err++; $display("FAIL b2b_pop_count: got %0d, want 2", pop_cyc.size() - p0);
    end else begin
      n_cmp++;
      if (pop_cyc[p0] - t0 !== 2 || pop_cyc[p0 + 1] - pop_cyc[p0] !== 5) begin
        n_err++; $display("FAIL b2b_pop_timing: got latency=%0d gap=%0d, want 2 and 5",
                          pop_cyc[p0] - t0, pop_cyc[p0 + 1] - pop_cyc[p0]);
      end
    end
    n_cmp++;
    if (hdrs.size() - h0 !== 2 || hdrs[h0] !== 12'h801 || hdrs[h0 + 1] !== 12'hC02) begin
      n_err++; $display("FAIL b2b_hdrs: got n=%0d first=%h, want n=2 hdrs 801,c02", hdrs.size() - h0, hdrs[h0]);
    end
    n_cmp++;
    if (bad_pop !== 0) begin n_err++; $display("FAIL pop_while_empty: got %0d, want 0", bad_pop); end
  endtask

  task automatic test_reset_mid();
    int b0, r0, p0, hit;
    b0 = beats.size(); r0 = rls_blks.size(); p0 = pop_cyc.size();
    @(posedge CLK); #1;
    push(4'd4, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    push(4'd9, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0);
    push(4'd12, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (pop_cyc.size() - p0 == 2 && SAMP_VLD && beats.size() - b0 >= NSAMP + 2) begin hit = 1; break; end
    end
    n_cmp++;
    if (hit !== 1) begin n_err++; $display("FAIL rstmid_reach_samp: got %0d, want 1", hit); end
    @(posedge CLK); #1;
    RST = 1'b1;
    wr_ptr = rd_ptr;
    #1;
    n_cmp++;
    if ({POP, HDR_VLD, SAMP_VLD, SAMP_LAST, RLS, BUSY, HDR, SAMP_BLK, SAMP_IDX, RLS_BLK, NEVT} !== 38'd0) begin
      n_err++; $display("FAIL rstmid_outputs: got SAMP_VLD=%b BUSY=%b RLS=%b NEVT=%0d HDR=%h, want all 0",
                        SAMP_VLD, BUSY, RLS, NEVT, HDR);
    end
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (10) @(negedge CLK);
    n_cmp++;
    if (rls_blks.size() - r0 !== 1 || rls_blks[r0] !== 4'd4) begin
      n_err++; $display("FAIL rstmid_rls: got n=%0d blk=%0d, want n=1 blk=4", rls_blks.size() - r0, rls_blks[r0]);
    end
    n_cmp++;
    if ({BUSY, NEVT} !== 9'd0) begin
      n_err++; $display("FAIL rstmid_after: got BUSY=%b NEVT=%0d, want 0 0", BUSY, NEVT);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_second_block();
    test_ovf();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
